// File: rtl/ef_smsdac_mse_tree.sv
// ef_smsdac_mse_tree: tree mismatch-shaping encoder, BITS-bit code to 2^BITS
// unit elements whose popcount equals the code.
// Optional EF_SMSDAC_MSE_SUMCHK_EN adds a sticky popcount checker (o_sum_err).
module ef_smsdac_mse_tree #(
  parameter int unsigned BITS = 4,
  parameter int unsigned PIPE = 0,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [BITS-1:0]      i_x,
  input  logic                 i_en,
  output logic                 o_valid,
  output logic [(1<<BITS)-1:0] o_el
`ifdef EF_SMSDAC_MSE_SUMCHK_EN
  ,
  output logic                 o_sum_err
`endif
);

  localparam int unsigned NEL      = 1 << BITS;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  logic [15:0] lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  for (genvar l = 0; l < BITS; l++) begin : g_layer
    localparam int unsigned NN = 1 << l;
    localparam int unsigned CW = BITS + 1 - l;
    localparam int unsigned OW = BITS - l;

    logic [NN*CW-1:0]   cin;
    logic               vin;
    logic [NN-1:0]      rj;
    logic [NN-1:0]      q1;
    logic [NN-1:0]      q0;
    logic [NN-1:0]      sgn;
    logic [NN-1:0]      odd;
    logic [2*NN*OW-1:0] cout;
    logic [2*NN*OW-1:0] nxt_d;
    logic               nxt_v;
`ifdef EF_SMSDAC_MSE_SUMCHK_EN
    logic [BITS-1:0]    xin;
    logic [BITS-1:0]    nxt_x;
`endif

    if (l == 0) begin : g_src
      assign cin = {1'b0, i_x};
      assign vin = i_valid;
`ifdef EF_SMSDAC_MSE_SUMCHK_EN
      assign xin = i_x;
`endif
    end else begin : g_src
      assign cin = g_layer[l-1].nxt_d;
      assign vin = g_layer[l-1].nxt_v;
`ifdef EF_SMSDAC_MSE_SUMCHK_EN
      assign xin = g_layer[l-1].nxt_x;
`endif
    end

    // children of node n land at 2n (lo, lower elements) and 2n+1 (hi)
    for (genvar n = 0; n < NN; n++) begin : g_node
      logic [OW-1:0] half;
      assign rj[n]   = lfsr[(NN - 1 + n) % 16];
      assign odd[n]  = cin[n*CW];
      assign sgn[n]  = i_en ? q0[n] : rj[n];
      assign half    = cin[n*CW+1 +: OW];
      assign cout[(2*n)*OW +: OW]   = half + OW'(odd[n] & ~sgn[n]);
      assign cout[(2*n+1)*OW +: OW] = half + OW'(odd[n] & sgn[n]);
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        q1 <= '0;
        q0 <= '0;
      end else if (vin && i_en) begin
        for (int unsigned n = 0; n < NN; n++) begin
          if (odd[n]) begin
            q1[n] <= ~q1[n];
            q0[n] <= q1[n] ? rj[n] : ~q0[n];
          end
        end
      end
    end

    // with PIPE=0 only the last layer registers, forming the output register
    if (PIPE != 0 || l == BITS - 1) begin : g_reg
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          nxt_v <= 1'b0;
          nxt_d <= '0;
`ifdef EF_SMSDAC_MSE_SUMCHK_EN
          nxt_x <= '0;
`endif
        end else begin
          nxt_v <= vin;
          if (vin) begin
            nxt_d <= cout;
`ifdef EF_SMSDAC_MSE_SUMCHK_EN
            nxt_x <= xin;
`endif
          end
        end
      end
    end else begin : g_comb
      assign nxt_v = vin;
      assign nxt_d = cout;
`ifdef EF_SMSDAC_MSE_SUMCHK_EN
      assign nxt_x = xin;
`endif
    end
  end

  assign o_el    = g_layer[BITS-1].nxt_d;
  assign o_valid = g_layer[BITS-1].nxt_v;

`ifdef EF_SMSDAC_MSE_SUMCHK_EN
  localparam int unsigned PW = BITS + 1;

  logic [PW-1:0] el_pop;

  always_comb begin
    el_pop = '0;
    for (int unsigned e = 0; e < NEL; e++) begin
      el_pop = el_pop + PW'(o_el[e]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sum_err <= 1'b0;
    end else if (o_valid && (el_pop != {1'b0, g_layer[BITS-1].nxt_x})) begin
      o_sum_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/ef_smsdac_mse_tree.md
Name: ef_smsdac_mse_tree

Overview:
- Parametrised, fully-segmented tree mismatch-shaping encoder.
- Takes a BITS-wide unsigned DAC code and drives 2^BITS unit-element bits whose popcount equals the code.
- Arranged as a BITS-layer binary tree of switching blocks, each with a first-order switching-sequence state machine, fed by an internal LFSR dither source.
- Optional per-layer pipelining and a valid qualifier, so shaping state advances only on real samples.

Parameters:
- BITS, 4, input code width; tree depth; unit-element count = 2^BITS.
- PIPE, 0, 0 = tree combinational with output register; 1 = register after every layer.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  i_x is a sample this cycle.
- i_x  input  BITS  unsigned code, 0..2^BITS-1.
- i_en  input  1  1 = mismatch shaping; 0 = state frozen, random split.
- o_valid  output  1  o_el carries an encoded sample.
- o_el  output  2^BITS  unit-element drive bits.

Behaviour:
- Reset (i_rst=1 at an edge): all switching states 2'b00, pipeline registers 0, o_el=0, o_valid=0, lfsr=SEED. Reset mid-stream discards all in-flight samples.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts left with feedback into bit0 every cycle after reset, independent of i_valid.
- Tree structure:
  - Layer l (0..BITS-1) has 2^l nodes n.
  - Node j = 2^l-1+n receives count c in 0..2^(BITS-l) and covers elements n*2^(BITS-l) .. (n+1)*2^(BITS-l)-1.
  - The hi child covers the upper half of that range; the lo child covers the lower half.
- Split rule:
  - c even: hi = lo = c/2.
  - c odd and s=1: hi=(c+1)/2, lo=(c-1)/2.
  - c odd and s=0: hi=(c-1)/2, lo=(c+1)/2.
  - At layer BITS-1, hi and lo are single o_el bits.
- Switching sign: s = i_en ? q0 : r_j, with r_j = lfsr[j mod 16].
- Node state machine (q1,q0), updated only when the node's input is valid, odd, and i_en=1:
  - q1 <= ~q1.
  - q0 <= q1 ? r_j : ~q0.
  - Otherwise it holds; i_en=0 freezes state.
- Sequence from reset for repeated odd inputs: s = 0, 1, then r, ~r, r', ~r', ...
- Latency:
  - PIPE=0: o_valid/o_el one cycle after i_valid.
  - PIPE=1: BITS cycles; each layer's state machine updates in the cycle its stage register is valid.
- Valid handling:
  - Stage valid bits propagate with the data.
  - When a stage is invalid, its state holds and its data register keeps its old value.
  - o_el holds its last value while o_valid=0.
- Throughput: one sample per cycle; no backpressure.
- Invariant: popcount(o_el) equals the associated i_x on every o_valid cycle.
- Node count arithmetic is (BITS+1-l) bits wide at layer l; no overflow is possible for legal inputs.
- i_en is sampled per layer in the cycle that layer processes a sample.

Optional Feature:
- Macro: EF_SMSDAC_MSE_SUMCHK_EN.
- When defined:
  - Adds output port o_sum_err (1 bit).
  - i_x is delayed alongside the pipeline; o_sum_err is set to 1 and held (sticky) when o_valid=1 and popcount(o_el) differs from the delayed i_x.
  - o_sum_err is cleared only by i_rst; reset value 0.
- When undefined: no port, no checker logic.

Test Plan:
- BITS=4, PIPE=0, i_en=1, i_valid=1, i_x=0 then 15 -> next cycles o_el=16'h0000, then exactly 15 ones; o_valid=1 one cycle after each input.
- Out of reset, i_x=1 applied twice -> first output 16'h0001 region (element in 0..7, s_root=0 sends the count lo); second output has its one in 8..15 (s_root=1).
- i_x=8 held 8 cycles -> root and middle layers never odd, states stay 00; leaf nodes alternate; every output popcount=8; each element pair toggles per leaf sequence.
- i_en=0 with random i_x for 100 cycles -> all node states unchanged from before; popcount(o_el)=i_x every valid cycle.
- PIPE=1, i_valid pattern 1,0,1,1, i_x=3,x,5,7 -> o_valid exactly 4 cycles after each valid input; outputs have popcount 3,5,7; no state change on the gap.
- Assert i_rst for one cycle mid-stream with PIPE=1 -> next cycle o_valid=0, o_el=0, states 00, lfsr=SEED; with EF_SMSDAC_MSE_SUMCHK_EN, o_sum_err stays 0 over 1000 random samples.
